instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 req_valid  input  1  encode request present.
REQ-004 req_ready  output  1  encoder can accept a request this cycle.
REQ-005 req_kind  input  2  00 data-processing, 01 memory, 10 branch, 11 illegal.
REQ-006 req_cond  input  4  condition field, copied to instr[31:28].
REQ-007 req_alu  input  2  DP operation: 00 add, 01 sub, 10 and, 11 orr.
REQ-008 req_s  input  1  DP set-flags bit.
REQ-009 req_imm  input  1  operand 2 is an immediate (DP and memory).
REQ-010 req_load  input  1  memory: 1 LDR, 0 STR.
REQ-011 req_rn, req_rd  input  4 each  register fields.
REQ-012 req_src2  input  12  operand 2 / offset field.
REQ-013 req_imm24  input  24  branch offset field.
REQ-014 out_valid  output  1  encoded word available.
REQ-015 out_ready  input  1  sink accepts word.
REQ-016 out_instr  output  32  encoded instruction.
REQ-017 out_addr  output  32  byte address for out_instr.
REQ-018 err  output  1  sticky illegal-request flag.

Function
REQ-019 Request handshake = req_valid & req_ready; output handshake = out_valid & out_ready.
REQ-020 Accepted requests are encoded combinationally, then written into a 4-entry FIFO in acceptance order.
REQ-021 req_ready SHALL be 1 iff FIFO count < 4; it is derived from registered count only and never depends on out_ready.
REQ-022 out_valid SHALL be 1 iff count > 0; out_instr is the FIFO head.
REQ-023 Minimum latency: a request accepted in cycle N is presented on out_instr no earlier than cycle N+1.
REQ-024 While out_valid=1 and out_ready=0, out_instr and out_addr SHALL hold stable.
REQ-025 Simultaneous enqueue and dequeue: count unchanged, both succeed; at count 4 no enqueue occurs.
REQ-026 Read and write pointers are 2 bits wide and wrap 3->0.
REQ-027 DP encoding: [27:26]=00, [25]=req_imm, [24:21]=0100/0010/0000/1100 for req_alu 00/01/10/11, [20]=req_s, [19:16]=rn, [15:12]=rd, [11:0]=src2.
REQ-028 Memory encoding: [27:26]=01, [25]=~req_imm, [24:21]=1100, [20]=req_load, [19:16]=rn, [15:12]=rd, [11:0]=src2.
REQ-029 Branch encoding: [27:24]=1010, [23:0]=req_imm24.
REQ-030 out_addr counter starts at 0, increments by 4 on each output handshake, and wraps modulo 2^32.

Reset
REQ-031 On reset: count=0, pointers=0, out_valid=0, req_ready=1 in the following cycle, out_addr=0, err=0.
REQ-032 Reset asserted mid-stream discards all buffered words without emitting them; a request presented during the reset cycle is not accepted.

Configuration
REQ-033 Macro INSTR_ENCODER_CHECK_EN.
- Defined: a req_kind=11 request is handshaken (consumed) but not enqueued, and err sets the next cycle and stays set until reset.
- Undefined: err is tied 0, and kind 11 is enqueued with [27:26]=11 and all other fields encoded as DP.

Verification
REQ-034 Encode check: cond E, kind 00, imm 1, alu add, s 0, rn 2, rd 1, src2 0x005 -> out_instr 0xE2821005, out_addr 0.
REQ-035 Encode check for a load, a register-operand SUBS and a branch, issued in that order:
- LDR: cond E, kind 01, imm 1, load 1, rn 4, rd 3, src2 0x008 -> 0xE5943008 at addr 0.
- SUBS: cond E, kind 00, imm 0, alu sub, s 1, rn 0, rd 0, src2 0x001 -> 0xE0500001 at addr 4.
- B: cond E, kind 10, imm24 0x000010 -> 0xEA000010 at addr 8.
REQ-036 Backpressure: out_ready=0 while issuing 5 requests -> 4 accepted, req_ready=0 afterwards, out_instr stable; raise out_ready -> 4 words emitted in order at addrs 0, 4, 8, 12.
REQ-037 Full-FIFO streaming: count=4, out_ready=1, req_valid=1 -> one word leaves per cycle, req_ready returns 1 the cycle after the first dequeue, no loss or duplication.
REQ-038 Reset mid-stream: 3 words buffered, assert reset for one cycle -> out_valid=0 and out_addr=0 the next cycle, and the next request is encoded at addr 0.
REQ-039 With INSTR_ENCODER_CHECK_EN defined: a kind 11 request -> no word emitted and err=1 persistently; a following valid request is emitted at the unchanged out_addr.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: encodes DP/memory/branch requests into 32-bit words queued in a 4-entry FIFO.
// Latency 1 cycle handshake-to-out_valid; req_ready drops only when the FIFO is full (registered count).
// Build option INSTR_ENCODER_CHECK_EN: kind-11 requests are consumed without a word and set sticky err.
module instr_encoder_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  logic [W-1:0] mem [4];
  logic [1:0]   wr_ptr;
  logic [1:0]   rd_ptr;
  logic [2:0]   count;
  logic         do_push;
  logic         do_pop;

  assign full    = (count == 3'd4);
  assign empty   = (count == 3'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module instr_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_kind,
  input  logic [3:0]  req_cond,
  input  logic [1:0]  req_alu,
  input  logic        req_s,
  input  logic        req_imm,
  input  logic        req_load,
  input  logic [3:0]  req_rn,
  input  logic [3:0]  req_rd,
  input  logic [11:0] req_src2,
  input  logic [23:0] req_imm24,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err
);
  logic        in_hs;
  logic        out_hs;
  logic        do_enq;
  logic        fifo_full;
  logic        fifo_empty;
  logic [3:0]  opc;
  logic [31:0] word;

  assign req_ready = ~fifo_full;
  assign out_valid = ~fifo_empty;
  assign in_hs     = req_valid & req_ready;
  assign out_hs    = out_valid & out_ready;

  always_comb begin
    case (req_alu)
      2'b01:   opc = 4'b0010;
      2'b10:   opc = 4'b0000;
      2'b11:   opc = 4'b1100;
      default: opc = 4'b0100;
    endcase
    // kind 00 and kind 11 share the DP layout; req_kind lands directly in [27:26]
    word = {req_cond, req_kind, req_imm, opc, req_s, req_rn, req_rd, req_src2};
    case (req_kind)
      2'b01:   word = {req_cond, 2'b01, ~req_imm, 4'b1100, req_load, req_rn, req_rd, req_src2};
      2'b10:   word = {req_cond, 4'b1010, req_imm24};
      default: ;
    endcase
  end

`ifdef INSTR_ENCODER_CHECK_EN
  logic is_illegal;
  logic err_q;

  assign is_illegal = (req_kind == 2'b11);
  assign do_enq     = in_hs & ~is_illegal;
  assign err        = err_q;

  always_ff @(posedge clk) begin
    if (reset)                   err_q <= 1'b0;
    else if (in_hs & is_illegal) err_q <= 1'b1;
  end
`else
  assign do_enq = in_hs;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)       out_addr <= 32'd0;
    else if (out_hs) out_addr <= out_addr + 32'd4;
  end

  instr_encoder_fifo #(.W(32)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (do_enq),
    .push_dat (word),
    .pop      (out_ready),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (out_instr)
  );
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized + directed bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;
  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [3:0]  req_cond;
  logic [1:0]  req_alu;
  logic        req_s;
  logic        req_imm;
  logic        req_load;
  logic [3:0]  req_rn;
  logic [3:0]  req_rd;
  logic [11:0] req_src2;
  logic [23:0] req_imm24;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [31:0] mq[$];
  logic [31:0] maddr = 0;
  bit          merr  = 0;

  instr_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_kind  (req_kind),
    .req_cond  (req_cond),
    .req_alu   (req_alu),
    .req_s     (req_s),
    .req_imm   (req_imm),
    .req_load  (req_load),
    .req_rn    (req_rn),
    .req_rd    (req_rd),
    .req_src2  (req_src2),
    .req_imm24 (req_imm24),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoder built from the field tables with plain arithmetic.
  function automatic logic [31:0] enc_now();
    int dp_opc[4] = '{4, 2, 0, 12};
    logic [31:0] w;
    w = 32'(req_cond) << 28;
    if (req_kind == 2'd2)
      w = w + (32'd10 << 24) + 32'(req_imm24);
    else if (req_kind == 2'd1)
      w = w + (32'd1 << 26) + (32'(!req_imm) << 25) + (32'd12 << 21) + (32'(req_load) << 20)
            + (32'(req_rn) << 16) + (32'(req_rd) << 12) + 32'(req_src2);
    else
      w = w + (32'(req_kind) << 26) + (32'(req_imm) << 25) + (32'(dp_opc[req_alu]) << 21)
            + (32'(req_s) << 20) + (32'(req_rn) << 16) + (32'(req_rd) << 12) + 32'(req_src2);
    return w;
  endfunction

  always @(posedge clk) begin : model_and_check
    bit acc;
    bit pop;
    acc = req_valid && (mq.size() < 4);
    pop = (mq.size() > 0) && out_ready;
    if (reset) begin
      mq.delete();
      maddr = 0;
      merr  = 0;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        maddr = maddr + 32'd4;
      end
      if (acc) begin
`ifdef INSTR_ENCODER_CHECK_EN
        if (req_kind == 2'd3) merr = 1;
        else mq.push_back(enc_now());
`else
        mq.push_back(enc_now());
`endif
      end
    end
    #2;
    chk("req_ready", 32'(req_ready), 32'(mq.size() < 4));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("out_instr", out_instr, mq[0]);
    chk("out_addr", out_addr, maddr);
    chk("err", 32'(err), 32'(merr));
  end

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic set_req(input logic [1:0] k, input logic [3:0] c, input logic [1:0] a,
                         input logic s, input logic im, input logic ld, input logic [3:0] rn,
                         input logic [3:0] rd, input logic [11:0] s2, input logic [23:0] i24);
    req_kind = k; req_cond = c; req_alu = a; req_s = s; req_imm = im; req_load = ld;
    req_rn = rn; req_rd = rd; req_src2 = s2; req_imm24 = i24;
  endtask

  task automatic rand_fields(input int kmax);
    set_req(2'($urandom_range(0, kmax)), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 4'($urandom), 4'($urandom), 12'($urandom), 24'($urandom));
  endtask

  task automatic issue();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 1'b1;
    rand_fields(2);
    tick();
    reset = 1'b0;
    req_valid = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; out_ready = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    do_reset();

    // single ADD immediate
    set_req(0, 4'hE, 0, 0, 1, 0, 4'd2, 4'd1, 12'h005, 0);
    issue();
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_instr", out_instr, 32'hE2821005);
    chk("add_addr", out_addr, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("add_drained", 32'(out_valid), 32'd0);
    chk("add_addr_next", out_addr, 32'd4);

    // LDR, SUBS, B in order
    out_ready = 1'b0;
    do_reset();
    set_req(1, 4'hE, 0, 0, 1, 1, 4'd4, 4'd3, 12'h008, 0);
    issue();
    set_req(0, 4'hE, 1, 1, 0, 0, 4'd0, 4'd0, 12'h001, 0);
    issue();
    set_req(2, 4'hE, 0, 0, 0, 0, 0, 0, 0, 24'h000010);
    issue();
    chk("ldr_instr", out_instr, 32'hE5943008);
    chk("ldr_addr", out_addr, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("subs_instr", out_instr, 32'hE0500001);
    chk("subs_addr", out_addr, 32'd4);
    tick();
    chk("b_instr", out_instr, 32'hEA000010);
    chk("b_addr", out_addr, 32'd8);
    tick();
    chk("seq_empty", 32'(out_valid), 32'd0);

    // backpressure: 5 offered, 4 taken
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rand_fields(2);
      issue();
    end
    chk("bp_ready_low", 32'(req_ready), 32'd0);
    tick();
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_addr", out_addr, 32'(i * 4));
      tick();
    end
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_addr_end", out_addr, 32'd16);

    // full-FIFO streaming
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rand_fields(2);
      issue();
    end
    chk("stream_full", 32'(req_ready), 32'd0);
    out_ready = 1'b1;
    req_valid = 1'b1;
    rand_fields(2);
    tick();
    chk("stream_ready_back", 32'(req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      rand_fields(2);
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("stream_drained", 32'(out_valid), 32'd0);

    // reset mid-stream
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      rand_fields(2);
      issue();
    end
    do_reset();
    rand_fields(2);
    issue();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_addr", out_addr, 32'd0);

    // kind 11 handling
    out_ready = 1'b1;
    do_reset();
`ifdef INSTR_ENCODER_CHECK_EN
    set_req(3, 4'hE, 0, 0, 1, 0, 4'd2, 4'd1, 12'h005, 0);
    issue();
    chk("ill_no_word", 32'(out_valid), 32'd0);
    chk("ill_err", 32'(err), 32'd1);
    tick();
    set_req(0, 4'hE, 0, 0, 1, 0, 4'd2, 4'd1, 12'h005, 0);
    issue();
    chk("ill_next_instr", out_instr, 32'hE2821005);
    chk("ill_next_addr", out_addr, 32'd0);
    chk("ill_err_sticky", 32'(err), 32'd1);
`else
    out_ready = 1'b0;
    set_req(3, 4'hE, 0, 0, 1, 0, 4'd2, 4'd1, 12'h005, 0);
    issue();
    chk("k3_instr", out_instr, 32'hEE821005);
    chk("k3_err", 32'(err), 32'd0);
`endif
    tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      req_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0) && (i % 200 > 40);
      rand_fields(3);
      tick();
    end
    reset = 1'b0;
    req_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
